// File: rtl/anvyl_kypd_pkg.sv
// Shared types and constants for the Anvyl 4x4 hex keypad scanner.
// Latency: none (package only).
// Backpressure: none (package only).
package anvyl_kypd_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} kypd_state_t;

   // Hex code per key, nibble index {row[1:0], col[1:0]}.
   // row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: 0 F E D
   localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] key_lookup(input logic [3:0] idx);
      key_lookup = KEYMAP[{idx, 2'b00} +: 4];
   endfunction

   // Active-low column drive: only column idx is pulled low.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      col_drive = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/anvyl_keypad_scan_debounce.sv
// Frame-level press/release debouncer with a stable-frame counter.
// Latency: outputs registered, update one cycle after the deciding frame_done.
// Backpressure: none; key_valid is a single-cycle pulse with no handshake.
module kypd_debounce
   import anvyl_kypd_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_done,
   input  logic       cand_valid,
   input  logic [3:0] cand_code,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

   kypd_state_t   state, state_nxt;
   logic [SW-1:0] count, count_nxt, count_inc;
   logic [3:0]    lat_code, lat_nxt, code_nxt;
   logic          valid_nxt, held_nxt;

   assign count_inc = count + SW'(1);

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         lat_code  <= 4'h0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         lat_code  <= lat_nxt;
         key_valid <= valid_nxt;
         key_code  <= code_nxt;
         key_held  <= held_nxt;
      end
   end

   // Next-state decision, taken only when a whole frame has been scanned.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      lat_nxt   = lat_code;
      valid_nxt = 1'b0;
      code_nxt  = key_code;
      held_nxt  = key_held;
      if (frame_done) begin
         case (state)
            IDLE: begin
               if (cand_valid) begin
                  state_nxt = CAND;
                  lat_nxt   = cand_code;
                  count_nxt = SW'(1);
               end
            end
            CAND: begin
               if (cand_valid && (cand_code == lat_code)) begin
                  if (count_inc == STABLE_MAX) begin
                     state_nxt = PRESSED;
                     count_nxt = '0;
                     valid_nxt = 1'b1;
                     code_nxt  = lat_code;
                     held_nxt  = 1'b1;
                  end else begin
                     count_nxt = count_inc;
                  end
               end else begin
                  state_nxt = IDLE;
                  count_nxt = '0;
               end
            end
            PRESSED: begin
               // Any key keeps us here: no auto-repeat until a full release.
               if (!cand_valid) begin
                  state_nxt = REL;
                  count_nxt = SW'(1);
               end else begin
                  count_nxt = '0;
               end
            end
            REL: begin
               if (!cand_valid) begin
                  if (count_inc == STABLE_MAX) begin
                     state_nxt = IDLE;
                     count_nxt = '0;
                     held_nxt  = 1'b0;
                  end else begin
                     count_nxt = count_inc;
                  end
               end else begin
                  state_nxt = PRESSED;
                  count_nxt = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/anvyl_keypad_scan.sv
// Anvyl 4x4 keypad column scanner, frame decoder and 6-digit hex entry register.
// Latency: key_valid one cycle after the last sample of the DEBOUNCE_SCANS-th stable frame.
// Backpressure: none; accepted digits shift into entry_value unconditionally.
module anvyl_keypad_scan
   import anvyl_kypd_pkg::*;
#(
   parameter int SCAN_TICKS     = 12500,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int CNT_W          = 20
)
(
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  col_out,
   input  logic [3:0]  row_in,
   input  logic        clear,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [23:0] entry_value
);

   logic [3:0]       row_meta, row_sync;
   logic [CNT_W-1:0] dwell;
   logic [1:0]       col_idx;
   logic [15:0]      snap, frame_vec, frame_low;
   logic             tc, frame_done;
   logic [4:0]       low_cnt;
   logic [3:0]       hit;
   logic             cand_valid;
   logic [3:0]       cand_code;

   assign tc         = (dwell == CNT_W'(SCAN_TICKS - 1));
   assign frame_done = tc && (col_idx == 2'd3);

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Dwell counter, column rotation and per-column row snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell   <= '0;
         col_idx <= 2'd0;
         col_out <= 4'b1110;
         snap    <= 16'hFFFF;
      end else if (tc) begin
         dwell                      <= '0;
         snap[{col_idx, 2'b00} +: 4] <= row_sync;
         col_idx                    <= col_idx + 2'd1;
         col_out                    <= col_drive(col_idx + 2'd1);
      end else begin
         dwell <= dwell + CNT_W'(1);
      end
   end

   // Frame decode: the current column's live sample completes the snapshot,
   // and only a single low bit names a key (multi-key ghosting is rejected).
   always_comb begin
      frame_vec = snap;
      frame_vec[{col_idx, 2'b00} +: 4] = row_sync;
      frame_low = ~frame_vec;
      low_cnt   = 5'd0;
      hit       = 4'd0;
      for (int b = 0; b < 16; b++) begin
         if (frame_low[b]) begin
            low_cnt = low_cnt + 5'd1;
            hit     = 4'(b);
         end
      end
   end

   // Bit index is {col,row}; the keymap is indexed {row,col}.
   assign cand_valid = (low_cnt == 5'd1);
   assign cand_code  = key_lookup({hit[1:0], hit[3:2]});

   kypd_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .frame_done(frame_done),
      .cand_valid(cand_valid),
      .cand_code (cand_code),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held)
   );

   // Entry register: accepted digits shift in at the low nibble; clear wins over history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_value <= 24'h0;
      end else if (key_valid) begin
         entry_value <= clear ? {20'h0, key_code} : {entry_value[19:0], key_code};
      end else if (clear) begin
         entry_value <= 24'h0;
      end
   end

endmodule

// File: tb/tb_anvyl_keypad_scan.sv
// Directed bench for anvyl_keypad_scan with a behavioural keypad matrix.
// Latency: frames are 32 cycles (SCAN_TICKS=8), presses accepted after 2 frames.
// Backpressure: not applicable.
module tb_anvyl_keypad_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  col_out;
   logic [3:0]  row_in;
   logic        clear = 1'b0;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [23:0] entry_value;

   logic [15:0] keys = 16'h0;   // pressed keys, index {row,col}
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int n_pulse = 0;

   always #5 clk = ~clk;

   anvyl_keypad_scan #(
      .SCAN_TICKS    (8),
      .DEBOUNCE_SCANS(2),
      .CNT_W         (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .col_out    (col_out),
      .row_in     (row_in),
      .clear      (clear),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_held   (key_held),
      .entry_value(entry_value)
   );

   // Keypad matrix: a held key shorts its row low while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
   end

   // Count key_valid pulses.
   always @(posedge clk) if (key_valid === 1'b1) n_pulse++;

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
      n_chk++;
      assert (got === want) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press one key (index {row,col}) for 2 frames, then release for 2 frames.
   task automatic press_key(input int idx);
      keys = 16'h0;
      keys[idx] = 1'b1;
      step(64);
      chk("press_pulse", {23'h0, key_valid}, 24'h1);
      keys = 16'h0;
      step(64);
   endtask

   initial begin
      logic [3:0] exp_col;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_col", {20'h0, col_out}, 24'hE);
      chk("rst_valid", {23'h0, key_valid}, 24'h0);
      chk("rst_code", {20'h0, key_code}, 24'h0);
      chk("rst_held", {23'h0, key_held}, 24'h0);
      chk("rst_entry", entry_value, 24'h0);
      rst = 1'b1;

      // Scan rotation, two full frames, no keys
      for (int i = 0; i < 64; i++) begin
         case ((i / 8) % 4)
            0: exp_col = 4'b1110;
            1: exp_col = 4'b1101;
            2: exp_col = 4'b1011;
            default: exp_col = 4'b0111;
         endcase
         chk("col_rot", {20'h0, col_out}, {20'h0, exp_col});
         step(1);
      end
      chk("idle_no_pulse", n_pulse, 0);

      // Clean press of key 6 (row1,col2) for 5 frames
      keys = 16'h0040;
      step(63);
      chk("k6_early", {23'h0, key_valid}, 24'h0);
      step(1);
      chk("k6_valid", {23'h0, key_valid}, 24'h1);
      chk("k6_code", {20'h0, key_code}, 24'h6);
      chk("k6_held", {23'h0, key_held}, 24'h1);
      step(1);
      chk("k6_one_cycle", {23'h0, key_valid}, 24'h0);
      step(95);
      chk("k6_single", n_pulse, 1);
      chk("k6_still_held", {23'h0, key_held}, 24'h1);
      chk("k6_entry", entry_value, 24'h000006);
      keys = 16'h0;
      step(63);
      chk("k6_rel_pending", {23'h0, key_held}, 24'h1);
      step(1);
      chk("k6_released", {23'h0, key_held}, 24'h0);

      // Bounce: key A present, absent, present, present
      keys = 16'h0008;
      step(32);
      keys = 16'h0;
      step(32);
      keys = 16'h0008;
      step(63);
      chk("kA_no_early", n_pulse, 1);
      step(1);
      chk("kA_valid", {23'h0, key_valid}, 24'h1);
      chk("kA_code", {20'h0, key_code}, 24'hA);
      keys = 16'h0;
      step(64);
      chk("kA_single", n_pulse, 2);
      chk("kA_released", {23'h0, key_held}, 24'h0);
      chk("kA_entry", entry_value, 24'h00006A);

      // Ghosting: keys 1 and 5 together for 4 frames
      keys = 16'h0021;
      step(128);
      chk("ghost_no_pulse", n_pulse, 2);
      chk("ghost_code", {20'h0, key_code}, 24'hA);
      chk("ghost_held", {23'h0, key_held}, 24'h0);
      keys = 16'h0;
      step(32);

      // Entry shift: 1..7
      press_key(0);
      press_key(1);
      press_key(2);
      press_key(4);
      press_key(5);
      press_key(6);
      press_key(8);
      chk("shift_entry", entry_value, 24'h234567);
      chk("shift_pulses", n_pulse, 9);

      // Clear coincident with F's key_valid
      keys = 16'h2000;
      step(64);
      chk("kF_valid", {23'h0, key_valid}, 24'h1);
      chk("kF_code", {20'h0, key_code}, 24'hF);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("clear_with_key", entry_value, 24'h00000F);
      keys = 16'h0;
      step(63);
      chk("kF_released", {23'h0, key_held}, 24'h0);

      // Clear alone
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("clear_alone", entry_value, 24'h0);
      step(31);

      // Mid-operation async reset with key 9 held
      keys = 16'h0400;
      step(40);
      rst = 1'b0;
      #1;
      chk("mrst_col", {20'h0, col_out}, 24'hE);
      chk("mrst_valid", {23'h0, key_valid}, 24'h0);
      chk("mrst_code", {20'h0, key_code}, 24'h0);
      chk("mrst_held", {23'h0, key_held}, 24'h0);
      chk("mrst_entry", entry_value, 24'h0);
      step(3);
      rst = 1'b1;
      step(63);
      chk("k9_early", {23'h0, key_valid}, 24'h0);
      step(1);
      chk("k9_valid", {23'h0, key_valid}, 24'h1);
      chk("k9_code", {20'h0, key_code}, 24'h9);
      chk("k9_held", {23'h0, key_held}, 24'h1);
      step(1);
      chk("k9_entry", entry_value, 24'h000009);
      keys = 16'h0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/anvyl_keypad_scan.md
Name: anvyl_keypad_scan

Overview:
Scans the Anvyl 4x4 hex keypad, which is the input counterpart of the 6-digit 7-segment display driver. It drives the column lines low one at a time and samples the active-low row lines through a synchronizer. Each key is debounced over whole scan frames, then encoded to a 4-bit hex code. Accepted digits shift into a 24-bit entry register, which feeds the display's 24-bit data input directly.

Parameters:
SCAN_TICKS, 12500, clk cycles each column stays driven (dwell); rows sampled on last tick of dwell
DEBOUNCE_SCANS, 4, consecutive full frames a key state must be stable before press/release is accepted
CNT_W, 20, width of dwell counter; must satisfy 2^CNT_W > SCAN_TICKS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
col_out  output  4  column drive, active-low, exactly one bit low at any time
row_in  input  4  row sense, active-low (pulled up), asynchronous to clk
clear  input  1  synchronous clear of entry_value
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  hex code of last accepted key, held until next press
key_held  output  1  high while accepted key is still down (until debounced release)
entry_value  output  24  last six accepted digits, newest in [3:0]

Behaviour:
- Reset (rst==0, async) sets: col_out=4'b1110, dwell counter=0, column index=0, synchronizer=4'b1111, key_valid=0, key_code=0, key_held=0, entry_value=0, FSM=IDLE, stable count=0.
- Synchronizer: two flops on row_in, reset to all ones. Only the second-stage value is used.
- Dwell counter runs 0..SCAN_TICKS-1, then wraps.
  - At terminal count, the synchronized rows for the current column are stored into a 16-bit frame snapshot at bits [col*4 +: 4].
  - At terminal count, the column index then advances 0->1->2->3->0 and col_out rotates: 1110, 1101, 1011, 0111.
- Frame completes at terminal count of column 3, every 4*SCAN_TICKS cycles. Frame decode:
  - exactly one row bit low across the frame -> candidate = keymap[row][col];
  - no bits low -> NONE;
  - two or more bits low -> NONE (ghosting rejected).
- Keymap (row, cols 0..3): row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 0 F E D.
- FSM, evaluated only at frame completion:
  - IDLE: candidate valid -> CAND, latch candidate, count=1.
  - CAND: same candidate -> count+1. Different key or NONE -> back to IDLE (count=0). When count reaches DEBOUNCE_SCANS -> PRESSED, and in that same cycle key_valid=1, key_code=candidate, key_held=1.
  - PRESSED: NONE -> REL, count=1. Any key (same or other) -> stay, count=0. No auto-repeat; another key needs a full release first.
  - REL: NONE -> count+1; when count reaches DEBOUNCE_SCANS -> IDLE, key_held=0. Any key -> back to PRESSED.
- Latency: key_valid asserts exactly at the end of the DEBOUNCE_SCANS-th consecutive agreeing frame.
- key_valid is registered and high for exactly one cycle.
- entry_value:
  - on key_valid: {entry_value[19:0], code}; oldest digit is dropped;
  - on clear alone: 0;
  - clear and key_valid in the same cycle: {20'h0, code}.
- Key state changes inside a frame are only seen at the sample points; glitches between samples are ignored by design.

Decomposition:
- Package anvyl_kypd_pkg holds:
  - FSM state enum {IDLE, CAND, PRESSED, REL};
  - NUM_COLS=4, NUM_ROWS=4;
  - 16-entry keymap constant, indexed {row,col};
  - column drive pattern function.
- One natural sub-module, kypd_debounce: the frame-level FSM plus stable counter. Inputs are frame_done, cand_valid and cand_code; outputs are key_valid, key_code and key_held. The top level keeps the scanner, snapshot, decode and entry register.

Test Plan:
- All benches run with SCAN_TICKS=8, DEBOUNCE_SCANS=2.
- Scan rotation: hold rst low 3 cycles, release, no keys -> col_out=1110 for cycles 0-7, then 1101, 1011, 0111, then repeats every 32 cycles; key_valid never asserts.
- Clean press: bench model pulls row1 low while col2 is low (key 6), held 5 frames -> one key_valid pulse at end of 2nd full frame, key_code=4'h6, key_held=1; on release key_held drops after 2 NONE frames.
- Bounce: key 'A' (row0,col3) present in frame 1, absent in frame 2, present in frames 3-4 -> single key_valid after frame 4, key_code=4'hA.
- Ghosting: keys 1 and 5 held together for 4 frames -> no key_valid, key_code unchanged.
- Entry shift: press 1,2,3,4,5,6,7 with releases between -> entry_value=24'h234567. Assert clear the same cycle as the key_valid for 'F' -> entry_value=24'h00000F.
- Mid-operation reset: pull rst low during CAND with key 9 held -> col_out=1110 and all outputs 0 immediately (async). After rst releases with 9 still held, key_valid fires after 2 full frames with code 4'h9.
